semafor_mon: RTL and testbench

SEMAFOR_MON -- requirements
Module: semafor_mon

---
 rtl/semafor_mon_if.sv | 39 +++
 rtl/semafor_mon.sv | 181 ++++++++++++++++++
 tb/tb_semafor_mon.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/semafor_mon_if.sv
// -----------------------------------------------------------------------------
// semafor_mon_if -- lamp observation bus for the traffic-light sequence monitor.
//
// Signals
//   divisor     expected phase length minus one, in clk cycles (driven by master)
//   red/yellow/green  lamp signals under observation (driven by master)
//   phase       decoded current legal phase 0..3 (driven by monitor)
//   done        terminal green phase is being held (driven by monitor)
//   seq_err     sticky sequence error (driven by monitor)
//   time_err    sticky phase-length error (driven by monitor)
//   last_dwell  length of the most recently completed phase (driven by monitor)
//
// Modports
//   master : the lamp source / environment side
//   slave  : the monitor side (semafor_mon)
// -----------------------------------------------------------------------------
interface semafor_mon_if #(
    parameter int M = 8
);
    logic [M-1:0] divisor;
    logic         red;
    logic         yellow;
    logic         green;
    logic [1:0]   phase;
    logic         done;
    logic         seq_err;
    logic         time_err;
    logic [M:0]   last_dwell;

    modport master (
        output divisor, red, yellow, green,
        input  phase, done, seq_err, time_err, last_dwell
    );

    modport slave (
        input  divisor, red, yellow, green,
        output phase, done, seq_err, time_err, last_dwell
    );
endinterface

// File: rtl/semafor_mon.sv
// -----------------------------------------------------------------------------
// semafor_mon -- traffic-light sequence and phase-length monitor.
//
// Watches L = {red,yellow,green} and checks that it steps through
// RED(100) -> YEL(010) -> YG(011) -> GRN(001), with each non-terminal phase
// lasting exactly divisor+1 cycles. GRN and ERR are terminal until clr.
//
// Ports
//   clk   clock, all state updates on the rising edge
//   clr   asynchronous active-high reset
//   mon   semafor_mon_if.slave: divisor and lamps in; phase, done, seq_err,
//         time_err, last_dwell out (all registered)
//
// Configuration
//   SEMAFOR_MON_SYNC_EN  when defined, L passes through a 2-flop synchronizer
//                        (reset value 100) and the first red phase after reset
//                        is not length-checked, since the synchronizer stretches
//                        it by two cycles.
// -----------------------------------------------------------------------------
module semafor_mon #(
    parameter int M = 8
) (
    input logic          clk,
    input logic          clr,
    semafor_mon_if.slave mon
);

    typedef enum logic [2:0] {
        ST_RED = 3'd0,
        ST_YEL = 3'd1,
        ST_YG  = 3'd2,
        ST_GRN = 3'd3,
        ST_ERR = 3'd4
    } state_t;

    localparam logic [2:0] PAT_RED = 3'b100;
    localparam logic [2:0] PAT_YEL = 3'b010;
    localparam logic [2:0] PAT_YG  = 3'b011;
    localparam logic [2:0] PAT_GRN = 3'b001;

    localparam logic [M:0] CNT_MAX = {(M+1){1'b1}};
    localparam logic [M:0] CNT_ONE = {{M{1'b0}}, 1'b1};

    state_t     state_q, state_d;
    logic [2:0] pat_q, pat_d;
    logic [M:0] cnt_q, cnt_d;
    logic [1:0] phase_q, phase_d;
    logic       done_q, done_d;
    logic       seq_err_q, seq_err_d;
    logic       time_err_q, time_err_d;
    logic [M:0] last_dwell_q, last_dwell_d;

    logic [2:0] lamp_s;
    logic [2:0] obs_s;
    logic       chk_en_s;
    logic [M:0] target_s;

    assign lamp_s   = {mon.red, mon.yellow, mon.green};
    // Expected dwell widened before the +1 so divisor = all-ones does not wrap.
    assign target_s = {1'b0, mon.divisor} + CNT_ONE;

`ifdef SEMAFOR_MON_SYNC_EN
    logic [2:0] sync1_q, sync2_q;
    logic       first_q, first_d;

    assign obs_s    = sync2_q;
    // The first red phase is lengthened by the synchronizer, so skip its check.
    assign chk_en_s = ~first_q;

    // Two-stage lamp synchronizer and first-phase marker.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= PAT_RED;
            sync2_q <= PAT_RED;
            first_q <= 1'b1;
        end else begin
            sync1_q <= lamp_s;
            sync2_q <= sync1_q;
            first_q <= first_d;
        end
    end
`else
    assign obs_s    = lamp_s;
    assign chk_en_s = 1'b1;
`endif

    // Next-state, dwell counting and flag logic.
    always_comb begin
        logic       succ_ok;
        logic [2:0] succ_pat;
        state_t     succ_state;
        logic [1:0] succ_phase;
        logic       timed;

        state_d      = state_q;
        pat_d        = pat_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        seq_err_d    = seq_err_q;
        time_err_d   = time_err_q;
        last_dwell_d = last_dwell_q;
`ifdef SEMAFOR_MON_SYNC_EN
        first_d      = first_q;
`endif

        // Legal successor of the current state; GRN and ERR have none.
        case (state_q)
            ST_RED: begin
                succ_ok = 1'b1; succ_pat = PAT_YEL; succ_state = ST_YEL; succ_phase = 2'd1; timed = 1'b1;
            end
            ST_YEL: begin
                succ_ok = 1'b1; succ_pat = PAT_YG;  succ_state = ST_YG;  succ_phase = 2'd2; timed = 1'b1;
            end
            ST_YG: begin
                succ_ok = 1'b1; succ_pat = PAT_GRN; succ_state = ST_GRN; succ_phase = 2'd3; timed = 1'b1;
            end
            default: begin
                succ_ok = 1'b0; succ_pat = 3'b000;  succ_state = ST_ERR; succ_phase = phase_q; timed = 1'b0;
            end
        endcase

        if (obs_s == pat_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            last_dwell_d = cnt_q;
            cnt_d        = CNT_ONE;
            pat_d        = obs_s;
`ifdef SEMAFOR_MON_SYNC_EN
            first_d      = 1'b0;
`endif
            if (timed && chk_en_s && (cnt_q != target_s)) begin
                time_err_d = 1'b1;
            end else begin
                time_err_d = time_err_q;
            end
            if (succ_ok && (obs_s == succ_pat)) begin
                state_d = succ_state;
                phase_d = succ_phase;
            end else begin
                state_d   = ST_ERR;
                seq_err_d = 1'b1;
            end
        end

        done_d = (state_d == ST_GRN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_RED;
            pat_q        <= PAT_RED;
            cnt_q        <= {(M+1){1'b0}};
            phase_q      <= 2'd0;
            done_q       <= 1'b0;
            seq_err_q    <= 1'b0;
            time_err_q   <= 1'b0;
            last_dwell_q <= {(M+1){1'b0}};
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            done_q       <= done_d;
            seq_err_q    <= seq_err_d;
            time_err_q   <= time_err_d;
            last_dwell_q <= last_dwell_d;
        end
    end

    assign mon.phase      = phase_q;
    assign mon.done       = done_q;
    assign mon.seq_err    = seq_err_q;
    assign mon.time_err   = time_err_q;
    assign mon.last_dwell = last_dwell_q;

endmodule

// File: tb/tb_semafor_mon.sv
// -----------------------------------------------------------------------------
// tb_semafor_mon -- scoreboard bench for semafor_mon.
// The driver applies lamps at the falling edge, advances a phase-level
// reference model and queues the outputs expected after the next rising edge.
// The monitor pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_semafor_mon;
    localparam int M    = 8;
    localparam int MAXC = (1 << (M + 1)) - 1;

    logic clk = 1'b0;
    logic clr;

    semafor_mon_if #(.M(M)) bus ();

    semafor_mon #(.M(M)) dut (
        .clk (clk),
        .clr (clr),
        .mon (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int done;
        int seq_err;
        int time_err;
        int last_dwell;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- reference model (phase level) ----------------
    logic [2:0] seq_pat [4];
    int         stage;       // index into seq_pat of the current legal phase
    bit         in_err;
    logic [2:0] cur_pat;
    int         run_len;
    int         m_last;
    bit         m_seq, m_time;
    bit         skip_first;
    logic [2:0] m_sync0, m_sync1;

    task automatic model_reset();
        stage   = 0;
        in_err  = 1'b0;
        cur_pat = 3'b100;
        run_len = 0;
        m_last  = 0;
        m_seq   = 1'b0;
        m_time  = 1'b0;
        m_sync0 = 3'b100;
        m_sync1 = 3'b100;
`ifdef SEMAFOR_MON_SYNC_EN
        skip_first = 1'b1;
`else
        skip_first = 1'b0;
`endif
    endtask

    task automatic model_step(input logic [2:0] l, input int div);
        logic [2:0] s;
`ifdef SEMAFOR_MON_SYNC_EN
        s       = m_sync1;
        m_sync1 = m_sync0;
        m_sync0 = l;
`else
        s = l;
`endif
        if (s == cur_pat) begin
            run_len = (run_len < MAXC) ? run_len + 1 : MAXC;
        end else begin
            if (!in_err && stage < 3 && !skip_first && run_len != div + 1) m_time = 1'b1;
            skip_first = 1'b0;
            if (!in_err && stage < 3 && s == seq_pat[stage + 1]) stage = stage + 1;
            else begin
                in_err = 1'b1;
                m_seq  = 1'b1;
            end
            m_last  = run_len;
            run_len = 1;
            cur_pat = s;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.phase      = stage;
        e.done       = (!in_err && stage == 3) ? 1 : 0;
        e.seq_err    = m_seq ? 1 : 0;
        e.time_err   = m_time ? 1 : 0;
        e.last_dwell = m_last;
        return e;
    endfunction

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".phase"},      int'(bus.phase),      e.phase);
        chk({tag, ".done"},       int'(bus.done),       e.done);
        chk({tag, ".seq_err"},    int'(bus.seq_err),    e.seq_err);
        chk({tag, ".time_err"},   int'(bus.time_err),   e.time_err);
        chk({tag, ".last_dwell"}, int'(bus.last_dwell), e.last_dwell);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk_all("cyc", e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] l, input int div, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clr         = 1'b0;
            bus.red     = l[2];
            bus.yellow  = l[1];
            bus.green   = l[0];
            bus.divisor = div[M-1:0];
            model_step(l, div);
            exp_q.push_back(model_out());
        end
    endtask

    // Asynchronous clear: outputs must drop before any clock edge.
    task automatic do_clr();
        exp_t r;
        @(negedge clk);
        clr = 1'b1;
        #1;
        r = '{0, 0, 0, 0, 0};
        chk_all("async_clr", r);
        model_reset();
        exp_q.push_back(model_out());
    endtask

    task automatic clean_run(input int div, input int grn_len);
        drive(3'b100, div, div + 1);
        drive(3'b010, div, div + 1);
        drive(3'b011, div, div + 1);
        drive(3'b001, div, grn_len);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        seq_pat[0] = 3'b100;
        seq_pat[1] = 3'b010;
        seq_pat[2] = 3'b011;
        seq_pat[3] = 3'b001;
        clr         = 1'b1;
        bus.red     = 1'b1;
        bus.yellow  = 1'b0;
        bus.green   = 1'b0;
        bus.divisor = 8'd3;
        model_reset();
        #1;
        chk_all("reset", '{0, 0, 0, 0, 0});
        @(negedge clk);

        // Clean run, divisor 3.
        clean_run(3, 6);

        // Short yellow phase.
        do_clr();
        drive(3'b100, 3, 4);
        drive(3'b010, 3, 3);
        drive(3'b011, 3, 4);
        drive(3'b001, 3, 4);

        // Skipped yellow: order error from red, then further change.
        do_clr();
        drive(3'b100, 3, 4);
        drive(3'b011, 3, 3);
        drive(3'b001, 3, 3);

        // Leaving green, then clear and a fresh clean run.
        do_clr();
        clean_run(3, 3);
        drive(3'b100, 3, 3);
        do_clr();
        clean_run(3, 4);

        // Divisor 255: 256-cycle phases, then green held past saturation.
        do_clr();
        clean_run(255, 600);
        drive(3'b100, 255, 2);

        // Divisor 0: single-cycle phases and an illegal 000 pattern.
        do_clr();
        clean_run(0, 2);
        do_clr();
        drive(3'b100, 0, 1);
        drive(3'b000, 0, 2);

        // Randomized runs with occasional wrong lengths and patterns.
        for (int r = 0; r < 40; r++) begin
            int div;
            do_clr();
            div = $urandom_range(0, 5);
            for (int st = 0; st < 4; st++) begin
                int         len;
                logic [2:0] pat;
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, div + 3) : div + 1;
                pat = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : seq_pat[st];
                if (st == 3) len = $urandom_range(1, 6);
                drive(pat, div, len);
            end
            if ($urandom_range(0, 2) == 0) drive(3'($urandom_range(0, 7)), div, 2);
        end

        // Let the monitor drain the queue.
        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
